sync_fifo_ram: RTL

//  Single-clock FIFO built on a simple dual-port block RAM, with parametrised width and depth.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_ram_sdp_ram_core.sv | 31 +++
 rtl/sync_fifo_ram.sv | 84 ++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the block-RAM FIFO
package sync_fifo_pkg;
  function automatic int rd_latency(input int output_reg);
    return (output_reg != 0) ? 2 : 1;
  endfunction
  function automatic int default_afull(input int addr_width);
    return (1 << addr_width) - 4;
  endfunction
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ram_sdp_ram_core.sv
// sdp_ram_core: inferred simple dual-port RAM with optional reset-able output register
module sdp_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q;
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) q <= mem[rd_addr];
  end
  if (OUTPUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk or posedge rst)
      if (rst) rd_data <= '0;
      else rd_data <= q;
  end else begin : g_noreg
    logic unused_rst;
    assign unused_rst = rst;
    assign rd_data = q;
  end
endmodule

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock FIFO over a simple dual-port RAM with count, flags and error pulses
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int OUTPUT_REG    = 0,
  parameter int AFULL_THRESH  = default_afull(ADDR_WIDTH),
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int PW  = ptr_width(ADDR_WIDTH);
  localparam int LAT = rd_latency(OUTPUT_REG);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_CNT   = PW'(AEMPTY_THRESH);
  if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_params
    $error("sync_fifo_ram: need AEMPTY_THRESH < AFULL_THRESH <= 2**ADDR_WIDTH");
  end
  logic [PW-1:0]  wr_ptr, rd_ptr, count_next;
  logic [LAT-1:0] vpipe;
  logic           wr_acc, rd_acc;
  always_comb begin
    wr_acc     = wr_en & ~full;
    rd_acc     = rd_en & ~empty;
    count_next = count + PW'(wr_acc) - PW'(rd_acc);
  end
  // flags are registered from count_next so they move on the same edge as count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      vpipe        <= '0;
    end else begin
      wr_ptr       <= wr_ptr + PW'(wr_acc);
      rd_ptr       <= rd_ptr + PW'(rd_acc);
      count        <= count_next;
      full         <= count_next == FULL_CNT;
      almost_full  <= count_next >= AF_CNT;
      empty        <= count_next == '0;
      almost_empty <= count_next <= AE_CNT;
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
      vpipe        <= LAT'({vpipe, rd_acc});
    end
  end
  assign rd_valid = vpipe[LAT-1];
  sdp_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .OUTPUT_REG(OUTPUT_REG)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(wr_data),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(rd_data)
  );
endmodule
